// File: rtl/regs_pkg.sv
// Shared definitions for the multi-port register file and its zero-fill controller.
package regs_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 32;   // 32 for RV32I, 16 for RV32E

    // Zero-fill controller states: CLEAR walks the array, RUN is normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regs_clr_fsm.sv
// Zero-fill sequencer: walks addresses 1..DEPTH-1, one per cycle, after reset
// (optionally) and on every clear request issued while running.
module regs_clr_fsm
    import regs_pkg::*;
#(
    parameter int DEPTH          = DEPTH_DEFAULT,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    output logic          o_busy,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_clr_we
);

    localparam state_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [AW-1:0] CNT_FIRST   = AW'(1);
    localparam logic [AW-1:0] CNT_LAST    = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // State and counter registers; address 0 is never stored, so counting starts at 1.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= CNT_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a clear request only matters in RUN; CLEAR ends at the last address.
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                cnt_d = CNT_FIRST;
                if (i_clr) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = CNT_FIRST;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = CNT_FIRST;
            end
        endcase
    end

    // Outputs: the array is zeroed at the counter address for every CLEAR cycle.
    always_comb begin
        o_busy     = (state_q == CLEAR);
        o_clr_we   = (state_q == CLEAR);
        o_clr_addr = cnt_q;
    end

endmodule

// File: rtl/regs_mp.sv
// Multi-port RISC-V integer register file: x0 hard-wired to zero, registered
// reads, optional write-to-read forwarding and a hardware zero-fill sequence.
module regs_mp
    import regs_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int DEPTH          = DEPTH_DEFAULT,  // only 16 or 32
    parameter int RPORTS         = 2,              // 1..4
    parameter int WPORTS         = 1,              // 1..2
    parameter int PASS_THROUGH   = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ce,
    input  logic [RPORTS*AW-1:0]   i_addr_rd,
    input  logic [WPORTS-1:0]      i_we,
    input  logic [WPORTS*AW-1:0]   i_addr_wr,
    input  logic [WPORTS*XLEN-1:0] i_dat_wr,
    input  logic                   i_clr,
    output logic [RPORTS*XLEN-1:0] o_dat_rd,
    output logic                   o_busy
);

    logic [XLEN-1:0]        mem_q [DEPTH];
    logic                   busy;
    logic                   clr_we;
    logic [AW-1:0]          clr_addr;
    logic [WPORTS-1:0]      wr_ok;
    logic [RPORTS*XLEN-1:0] rd_d, rd_q;

    regs_clr_fsm #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr_fsm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_clr),
        .o_busy     (busy),
        .o_clr_addr (clr_addr),
        .o_clr_we   (clr_we)
    );

    // A user write qualifies only in RUN, with i_ce, to a nonzero address, and not alongside a clear request.
    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < WPORTS; w++) begin
            wr_ok[w] = i_ce && i_we[w] && (i_addr_wr[w*AW +: AW] != '0) && !busy && !i_clr;
        end
    end

    // Storage array; later write ports are applied last so they win address collisions.
    // NOTE: the array has no reset so it maps onto distributed RAM; the zero-fill sequence defines its contents.
    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            for (int w = 0; w < WPORTS; w++) begin
                if (wr_ok[w]) begin
                    mem_q[i_addr_wr[w*AW +: AW]] <= i_dat_wr[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Read select: zero while clearing or for x0, else array data overridden by the winning same-cycle write.
    always_comb begin
        rd_d = '0;
        for (int p = 0; p < RPORTS; p++) begin
            if (!busy && (i_addr_rd[p*AW +: AW] != '0)) begin
                rd_d[p*XLEN +: XLEN] = mem_q[i_addr_rd[p*AW +: AW]];
                for (int w = 0; w < WPORTS; w++) begin
                    if ((PASS_THROUGH != 0) && wr_ok[w] &&
                        (i_addr_wr[w*AW +: AW] == i_addr_rd[p*AW +: AW])) begin
                        rd_d[p*XLEN +: XLEN] = i_dat_wr[w*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Read data register, sampled every cycle independent of i_ce.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign o_dat_rd = rd_q;
    assign o_busy   = busy;

endmodule

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp: three instances cover forwarding on/off,
// dual write ports, RV32E depth and clear-on-reset disabled.
module tb_regs_mp;

    logic clk = 1'b0;
    logic rst;

    // Instances A (forwarding) and C (no forwarding) share one stimulus set.
    logic        a_ce, a_clr;
    logic [0:0]  a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic [9:0]  a_ra;
    logic [63:0] a_rd, c_rd;
    logic        a_busy, c_busy;

    // Instance B: DEPTH=16, two write ports, one read port, no clear on reset.
    logic        b_ce, b_clr;
    logic [1:0]  b_we;
    logic [7:0]  b_wa;
    logic [63:0] b_wd;
    logic [3:0]  b_ra;
    logic [31:0] b_rd;
    logic        b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    regs_mp #(.XLEN(32), .DEPTH(32), .RPORTS(2), .WPORTS(1), .PASS_THROUGH(1), .CLEAR_ON_RESET(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_ce(a_ce), .i_addr_rd(a_ra), .i_we(a_we), .i_addr_wr(a_wa),
        .i_dat_wr(a_wd), .i_clr(a_clr), .o_dat_rd(a_rd), .o_busy(a_busy));

    regs_mp #(.XLEN(32), .DEPTH(32), .RPORTS(2), .WPORTS(1), .PASS_THROUGH(0), .CLEAR_ON_RESET(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_ce(a_ce), .i_addr_rd(a_ra), .i_we(a_we), .i_addr_wr(a_wa),
        .i_dat_wr(a_wd), .i_clr(a_clr), .o_dat_rd(c_rd), .o_busy(c_busy));

    regs_mp #(.XLEN(32), .DEPTH(16), .RPORTS(1), .WPORTS(2), .PASS_THROUGH(1), .CLEAR_ON_RESET(0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_ce(b_ce), .i_addr_rd(b_ra), .i_we(b_we), .i_addr_wr(b_wa),
        .i_dat_wr(b_wd), .i_clr(b_clr), .o_dat_rd(b_rd), .o_busy(b_busy));

    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;   // expected, forwarding instance
        logic [31:0] c0, c1;   // expected, non-forwarding instance
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts consecutive busy samples (one per cycle, at negedge), optionally pulsing clear mid-sequence.
    task automatic wait_clear(input bit sel_b, input int limit, input int pulse_at,
                              output int n, output int rd_bad);
        n      = 0;
        rd_bad = 0;
        while (n < limit) begin
            if (sel_b ? !b_busy : !a_busy) break;
            n++;
            if (!sel_b && (a_rd != '0 || c_rd != '0)) rd_bad++;
            if (sel_b && b_rd != '0) rd_bad++;
            if (sel_b) b_clr = (n == pulse_at);
            else       a_clr = (n == pulse_at);
            @(negedge clk);
        end
    endtask

    task automatic b_step(input string name, input logic ce, input logic [1:0] we,
                          input logic [3:0] wa0, input logic [3:0] wa1,
                          input logic [31:0] wd0, input logic [31:0] wd1,
                          input logic [3:0] ra, input logic [31:0] exp);
        b_ce = ce;
        b_we = we;
        b_wa = {wa1, wa0};
        b_wd = {wd1, wd0};
        b_ra = ra;
        @(negedge clk);
        check(name, {32'h0, b_rd}, {32'h0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad;

        vecs[0] = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b0, 1'b1, 5'd6,  32'hCAFEF00D, 5'd5, 5'd6,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 5'd7,  32'h12345678, 5'd7, 5'd6,  32'h12345678, 32'h0,        32'h0,        32'h0};
        vecs[3] = '{1'b1, 1'b0, 5'd8,  32'hFFFFFFFF, 5'd7, 5'd8,  32'h12345678, 32'h0,        32'h12345678, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd6,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[5] = '{1'b1, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0, 32'hA5A5A5A5, 32'h0,        32'h0,        32'h0};
        vecs[6] = '{1'b1, 1'b1, 5'd5,  32'h00000001, 5'd5, 5'd31, 32'h00000001, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5};
        vecs[7] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5, 5'd7,  32'h00000001, 32'h12345678, 32'h00000001, 32'h12345678};
        vecs[8] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0, 5'd6,  32'h0,        32'h0,        32'h0,        32'h0};

        rst   = 1'b1;
        a_ce  = 1'b0; a_we = '0; a_wa = '0; a_wd = '0; a_ra = {5'd31, 5'd5}; a_clr = 1'b0;
        b_ce  = 1'b0; b_we = '0; b_wa = '0; b_wd = '0; b_ra = '0;            b_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy_a", {63'h0, a_busy}, 64'h1);
        check("rst_busy_c", {63'h0, c_busy}, 64'h1);
        check("rst_busy_b", {63'h0, b_busy}, 64'h0);
        check("rst_rd_a", a_rd, 64'h0);
        check("rst_rd_b", {32'h0, b_rd}, 64'h0);

        // Reset asserted 10 cycles into CLEAR restarts the whole sequence
        rst = 1'b0;
        wait_clear(1'b0, 10, 0, n, bad);
        check("clear_first10", 64'(n), 64'd10);
        rst = 1'b1;
        #1;
        check("midrst_busy", {63'h0, a_busy}, 64'h1);
        check("midrst_rd", a_rd, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_clear(1'b0, 200, 0, n, bad);
        check("clear_len_after_reset", 64'(n), 64'd31);
        check("clear_rd_zero", 64'(bad), 64'd0);
        check("clear_done_c", {63'h0, c_busy}, 64'h0);
        check("b_idle_after_reset", {63'h0, b_busy}, 64'h0);

        // Every register reads zero after the fill
        for (int i = 1; i < 32; i++) begin
            a_ra = {5'(32 - i), 5'(i)};
            @(negedge clk);
            check($sformatf("zero_a_x%0d", i), a_rd, 64'h0);
            check($sformatf("zero_c_x%0d", i), c_rd, 64'h0);
        end

        // Table-driven single-cycle vectors
        for (int i = 0; i < 9; i++) begin
            a_ce = vecs[i].ce;
            a_we = vecs[i].we;
            a_wa = vecs[i].wa;
            a_wd = vecs[i].wd;
            a_ra = {vecs[i].ra1, vecs[i].ra0};
            @(negedge clk);
            check($sformatf("vec%0d_fwd", i),   a_rd, {vecs[i].e1, vecs[i].e0});
            check($sformatf("vec%0d_nofwd", i), c_rd, {vecs[i].c1, vecs[i].c0});
        end

        // Clear request in RUN drops the same-cycle write; clear pulse inside CLEAR is ignored
        a_ce = 1'b1; a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h5555; a_ra = {5'd5, 5'd9};
        @(negedge clk);
        check("x9_fwd_a", {32'h0, a_rd[31:0]}, 64'h5555);
        check("x9_old_c", {32'h0, c_rd[31:0]}, 64'h0);
        a_clr = 1'b1; a_wd = 32'hAAAA;
        @(negedge clk);
        check("clr_busy", {63'h0, a_busy}, 64'h1);
        check("clr_drop_fwd_a", {32'h0, a_rd[31:0]}, 64'h5555);
        check("clr_drop_c", {32'h0, c_rd[31:0]}, 64'h5555);
        a_wa = 5'd12; a_wd = 32'hBEEF;
        wait_clear(1'b0, 200, 10, n, bad);
        check("clr_len", 64'(n), 64'd31);
        a_we = 1'b0; a_ce = 1'b0;
        a_ra = {5'd12, 5'd9};
        @(negedge clk);
        check("after_clr_x9_x12_a", a_rd, 64'h0);
        check("after_clr_x9_x12_c", c_rd, 64'h0);
        a_ra = {5'd7, 5'd5};
        @(negedge clk);
        check("after_clr_x5_x7_a", a_rd, 64'h0);

        // Instance B: zero-fill via clear only, then dual-port collisions
        b_clr = 1'b1;
        @(negedge clk);
        wait_clear(1'b1, 200, 0, n, bad);
        check("b_clr_len", 64'(n), 64'd15);
        check("b_clr_rd_zero", 64'(bad), 64'd0);
        b_step("b_collide_fwd", 1'b1, 2'b11, 4'd3,  4'd3, 32'h1111, 32'h2222, 4'd3,  32'h2222);
        b_step("b_collide_arr", 1'b1, 2'b00, 4'd0,  4'd0, 32'h0,    32'h0,    4'd3,  32'h2222);
        b_step("b_x0_write",    1'b1, 2'b11, 4'd4,  4'd0, 32'h4444, 32'h9,    4'd0,  32'h0);
        b_step("b_x4_read",     1'b1, 2'b00, 4'd0,  4'd0, 32'h0,    32'h0,    4'd4,  32'h4444);
        b_step("b_x15_ce_off",  1'b0, 2'b01, 4'd15, 4'd0, 32'hF00D, 32'h0,    4'd15, 32'h0);
        b_step("b_x15_fwd",     1'b1, 2'b01, 4'd15, 4'd0, 32'hF00D, 32'h0,    4'd15, 32'hF00D);
        b_step("b_x15_arr",     1'b0, 2'b00, 4'd0,  4'd0, 32'h0,    32'h0,    4'd15, 32'hF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
